fifo_rr_drain_arb: RTL and testbench

FIFO_RR_DRAIN_ARB -- requirements
Module: fifo_rr_drain_arb

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_rr_pick.sv | 35 +++
 rtl/fifo_rr_drain_arb.sv | 131 +++++++++++++
 tb/tb_fifo_rr_drain_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin prefetch-FIFO drain arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority picker: first set request searching from i_ptr upward, modulo N.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [2*N-1:0]   w_req2;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  // Duplicating the vector lets a plain part-select do the rotation.
  assign w_req2 = {i_req, i_req};
  assign w_rot  = w_req2[{1'b0, i_ptr} +: N];

  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= (IDX_W + 1)'(N)) ? IDX_W'(w_sum - (IDX_W + 1)'(N))
                                            : w_sum[IDX_W-1:0];
  assign o_any = |i_req;

endmodule

// File: rtl/fifo_rr_drain_arb.sv
// Drains N prefetch FIFOs in round-robin bursts of up to BURST_LEN beats into one
// registered output stage with valid/ready handshake.
module fifo_rr_drain_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          src_vld,
  input  logic [N_REQ*DATA_W-1:0]   src_data,
  output logic [N_REQ-1:0]          src_rd_en,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [clog2(N_REQ)-1:0]   out_src_id,
  output logic                      busy
);

  localparam int IDX_W = clog2(N_REQ);
  localparam int CNT_W = clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_grant, w_grant_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_free;
  logic             w_grant_vld;
  logic             w_pop;
  logic             w_release;

  logic             r_out_vld;
  logic [DATA_W-1:0] r_out_data;
  logic [IDX_W-1:0] r_out_src_id;

  logic [DATA_W-1:0] w_src_data [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_src_data[gi] = src_data[gi*DATA_W +: DATA_W];
  end

  fifo_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req (src_vld),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Output stage can take a new beat when empty or being emptied this cycle.
  assign w_free      = ~r_out_vld | out_rdy;
  assign w_grant_vld = src_vld[r_grant];
  assign w_pop       = (r_state == BURST) & w_grant_vld & w_free;

  always_comb begin
    src_rd_en = '0;
    if (w_pop) src_rd_en[r_grant] = 1'b1;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_nxt    = r_grant;
    w_beat_cnt_nxt = r_beat_cnt;
    w_release      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt    = BURST;
          w_grant_nxt    = w_pick_idx;
          w_beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (w_pop) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (r_beat_cnt == LAST_BEAT) w_release = 1'b1;
        end else if (!w_grant_vld && w_free) begin
          w_release = 1'b1;
        end
        if (w_release) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld    <= 1'b0;
      r_out_data   <= '0;
      r_out_src_id <= '0;
    end else if (w_pop) begin
      r_out_vld    <= 1'b1;
      r_out_data   <= w_src_data[r_grant];
      r_out_src_id <= r_grant;
    end else if (out_rdy) begin
      r_out_vld    <= 1'b0;
    end
  end

  assign out_vld    = r_out_vld;
  assign out_data   = r_out_data;
  assign out_src_id = r_out_src_id;
  assign busy       = (r_state == BURST);

endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// Directed bench for fifo_rr_drain_arb: modelled prefetch FIFOs feed tagged beats
// ({source id, sequence}) and the delivered stream is compared against hand-derived orders.
module tb_fifo_rr_drain_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int BL = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    src_vld;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_rd_en;
  logic [DW-1:0]   out_data;
  logic            out_vld;
  logic            out_rdy;
  logic [1:0]      out_src_id;
  logic            busy;

  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic [63:0] data;
  } beat_t;

  beat_t log_q[$];
  int    rem   [N];
  int    seq_n [N];
  int    bb    [N];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc   = 0;
  int    saved;

  logic [N-1:0] last_rd_en;
  logic         last_out_vld;
  logic         last_busy;
  logic [63:0]  last_out_data;
  logic [1:0]   last_out_id;

  always #5 clk = ~clk;

  fifo_rr_drain_arb #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .BURST_LEN (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_vld    (src_vld),
    .src_data   (src_data),
    .src_rd_en  (src_rd_en),
    .out_data   (out_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_src_id (out_src_id),
    .busy       (busy)
  );

  function automatic logic [63:0] mk(input int id, input int s);
    return {8'(id), 56'(s)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      src_vld[i]           = (rem[i] > 0);
      src_data[i*DW +: DW] = mk(i, seq_n[i]);
    end
  endtask

  // One clock: sample at negedge, then advance the FIFO models after the edge.
  task automatic tick();
    @(negedge clk);
    last_rd_en    = src_rd_en;
    last_out_vld  = out_vld;
    last_busy     = busy;
    last_out_data = out_data;
    last_out_id   = out_src_id;
    chk("rd_en_legal", 64'(($countones(src_rd_en) <= 1) && ((src_rd_en & ~src_vld) == '0)), 64'd1);
    if (out_vld && out_rdy) log_q.push_back('{cyc: cyc, id: out_src_id, data: out_data});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (last_rd_en[i]) begin
        rem[i]--;
        seq_n[i]++;
      end
    end
    cyc++;
    drive_src();
  endtask

  task automatic run_beats(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (log_q.size() < target && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_beat_count"}, 64'(log_q.size()), 64'(target));
  endtask

  task automatic chk_beat(input string tag, input int k, input int id, input int s, input int gap);
    string t;
    t = $sformatf("%s[%0d]", tag, k);
    chk({t, "_present"}, 64'(log_q.size() > k), 64'd1);
    if (k < log_q.size()) begin
      chk({t, "_id"}, 64'(log_q[k].id), 64'(id));
      chk({t, "_data"}, log_q[k].data, mk(id, s));
      if (gap > 0 && k > 0) chk({t, "_gap"}, 64'(log_q[k].cyc - log_q[k-1].cyc), 64'(gap));
    end
  endtask

  task automatic pulse_reset();
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive_src();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    out_rdy  = 1'b1;
    src_vld  = '0;
    src_data = '0;
    for (int i = 0; i < N; i++) begin
      rem[i]   = 0;
      seq_n[i] = i * 1000;
    end
    rem[1] = 3;
    drive_src();
    #12;
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_src_id", 64'(out_src_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(src_rd_en), 64'd0);
    rem[1] = 0;
    drive_src();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // No requests: stays idle.
    repeat (3) begin
      tick();
      chk("idle_busy", 64'(last_busy), 64'd0);
      chk("idle_rd_en", 64'(last_rd_en), 64'd0);
      chk("idle_out_vld", 64'(last_out_vld), 64'd0);
    end

    // A: single source 2, 20 beats -> 16 + bubble + 4.
    log_q.delete();
    bb[2] = seq_n[2];
    rem[2] = 20;
    drive_src();
    run_beats("A", 20, 60);
    for (int k = 0; k < 20; k++) chk_beat("A", k, 2, bb[2] + k, (k == 16) ? 2 : 1);
    repeat (4) tick();

    // D: ptr is now 3, only source 0 valid -> wrap to grant 0, then ptr 1.
    log_q.delete();
    bb[0] = seq_n[0];
    rem[0] = 3;
    drive_src();
    run_beats("D1", 3, 20);
    for (int k = 0; k < 3; k++) chk_beat("D1", k, 0, bb[0] + k, 1);
    repeat (4) tick();
    log_q.delete();
    bb[0] = seq_n[0];
    bb[1] = seq_n[1];
    rem[0] = 2;
    rem[1] = 2;
    drive_src();
    run_beats("D2", 4, 30);
    chk_beat("D2", 0, 1, bb[1],     0);
    chk_beat("D2", 1, 1, bb[1] + 1, 1);
    chk_beat("D2", 2, 0, bb[0],     3);
    chk_beat("D2", 3, 0, bb[0] + 1, 1);
    repeat (4) tick();

    // B: all sources valid -> bursts 0,1,2,3,0 of 16 with one bubble between.
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      bb[i]  = seq_n[i];
      rem[i] = 32;
    end
    drive_src();
    run_beats("B", 80, 200);
    for (int k = 0; k < 80; k++) begin
      int id;
      id = (k / 16) % 4;
      chk_beat("B", k, id, bb[id] + (k / 64) * 16 + (k % 16), (k % 16 == 0) ? 2 : 1);
    end
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive_src();
    repeat (6) tick();

    // C: source 1 runs dry after 5 beats -> early release, source 2 next.
    pulse_reset();
    bb[1] = seq_n[1];
    bb[2] = seq_n[2];
    rem[1] = 5;
    rem[2] = 10;
    drive_src();
    run_beats("C", 15, 60);
    for (int k = 0; k < 5; k++)  chk_beat("C", k, 1, bb[1] + k, 1);
    for (int k = 5; k < 15; k++) chk_beat("C", k, 2, bb[2] + k - 5, (k == 5) ? 3 : 1);
    repeat (4) tick();

    // E: downstream stall for 10 cycles while the granted source also goes empty.
    pulse_reset();
    bb[3] = seq_n[3];
    rem[3] = 20;
    drive_src();
    run_beats("E1", 5, 30);
    out_rdy = 1'b0;
    saved   = rem[3];
    rem[3]  = 0;
    drive_src();
    repeat (10) begin
      tick();
      chk("E_hold_vld", 64'(last_out_vld), 64'd1);
      chk("E_hold_data", last_out_data, mk(3, bb[3] + 5));
      chk("E_hold_id", 64'(last_out_id), 64'd3);
      chk("E_no_pop", 64'(last_rd_en), 64'd0);
      chk("E_no_release", 64'(last_busy), 64'd1);
    end
    rem[3]  = saved;
    out_rdy = 1'b1;
    drive_src();
    run_beats("E2", 20, 60);
    for (int k = 0; k < 20; k++) chk_beat("E", k, 3, bb[3] + k, (k == 5) ? 11 : ((k == 16) ? 2 : 1));
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive_src();
    repeat (4) tick();

    // F: reset mid-burst discards the held beat; arbitration restarts from source 0.
    pulse_reset();
    bb[2] = seq_n[2];
    rem[2] = 20;
    drive_src();
    run_beats("F1", 7, 30);
    bb[0] = seq_n[0];
    rem[0] = 4;
    drive_src();
    rst_n = 1'b0;
    #1;
    chk("F_rst_out_vld", 64'(out_vld), 64'd0);
    chk("F_rst_out_data", out_data, 64'd0);
    chk("F_rst_out_src_id", 64'(out_src_id), 64'd0);
    chk("F_rst_busy", 64'(busy), 64'd0);
    chk("F_rst_rd_en", 64'(src_rd_en), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q.delete();
    tick();
    chk("F_first_no_pop", 64'(last_rd_en), 64'd0);
    run_beats("F2", 6, 40);
    for (int k = 0; k < 4; k++) chk_beat("F2", k, 0, bb[0] + k, 1);
    chk_beat("F2", 4, 2, bb[2] + 8, 3);
    chk_beat("F2", 5, 2, bb[2] + 9, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
